shiftout_multi: RTL and testbench

Parametrised multi-lane shift-register driver for 74HC595-style chains. Drives CHANNELS independent serial data lanes from one frame of parallel data, sharing a single SHIFT_CLOCK and SHIFT_LATCH. Bit order (MSB/LSB first) is selectable per frame. Frames are accepted through a valid/ready handshake. Sits between system logic and off-chip shift-register chains; successor to the single-lane, LSB-only driver.

---
 rtl/shiftout_multi.sv | 184 ++++++++++++++++++
 tb/tb_shiftout_multi.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/shiftout_multi.sv
// Multi-lane 74HC595 chain driver: CHANNELS serial lanes sharing one shift clock and one latch.
// Optional readback of the chain outputs is enabled by defining SHIFTOUT_READBACK_EN.
module shiftout_multi #(
   parameter int DATA_WIDTH   = 32,
   parameter int CHANNELS     = 1,
   parameter int CLK_FREQ     = 12_000_000,
   parameter int FREQUENCY    = 1_000,
   parameter int CLKS_PER_BIT = CLK_FREQ / FREQUENCY
) (
   input  logic                           CLK,
   input  logic                           RST_N,
   input  logic [CHANNELS*DATA_WIDTH-1:0] IN_DATA,
   input  logic                           IN_MSB_FIRST,
   input  logic                           IN_VALID,
   output logic                           IN_READY,
   output logic                           SHIFT_CLOCK,
   output logic                           SHIFT_LATCH,
   output logic [CHANNELS-1:0]            SHIFT_DATA,
   output logic                           BUSY,
   output logic                           DONE
`ifdef SHIFTOUT_READBACK_EN
   ,
   input  logic [CHANNELS-1:0]            SHIFT_IN,
   output logic [CHANNELS*DATA_WIDTH-1:0] RD_DATA
`endif
);

   localparam int HALF = CLKS_PER_BIT / 2;
   localparam int CCW  = $clog2(CLKS_PER_BIT + 1);
   localparam int BCW  = $clog2(DATA_WIDTH + 1);
   localparam int FW   = CHANNELS * DATA_WIDTH;

   generate
      if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
         $error("shiftout_multi: CLKS_PER_BIT must be at least 2");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DATA  = 2'd1,
      LATCH = 2'd2
   } state_t;

   state_t         state;
   logic [CCW-1:0] clk_cnt;
   logic [BCW-1:0] bit_cnt;
   logic [FW-1:0]  frame;
   logic           msb_first;

   logic [CCW-1:0] clk_nxt;
   logic [BCW-1:0] bit_nxt;
   logic           period_end;
   logic           high_phase;

   assign clk_nxt    = clk_cnt + CCW'(1);
   assign bit_nxt    = bit_cnt + BCW'(1);
   assign period_end = (clk_cnt == CCW'(CLKS_PER_BIT - 1));
   assign high_phase = (clk_nxt >= CCW'(HALF));

   function automatic int lane_pos(input logic msb, input int idx);
      return msb ? (DATA_WIDTH - 1 - idx) : idx;
   endfunction

   // Gathers the bit at shift index idx from every lane of a frame.
   function automatic logic [CHANNELS-1:0] lane_bits(input logic [FW-1:0] data, input logic msb,
                                                     input int idx);
      logic [CHANNELS-1:0]   bits;
      logic [DATA_WIDTH-1:0] lane;
      bits = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         lane    = DATA_WIDTH'(data >> (c * DATA_WIDTH));
         lane    = lane >> lane_pos(msb, idx);
         bits[c] = lane[0];
      end
      return bits;
   endfunction

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state       <= IDLE;
         IN_READY    <= 1'b1;
         BUSY        <= 1'b0;
         DONE        <= 1'b0;
         SHIFT_CLOCK <= 1'b0;
         SHIFT_LATCH <= 1'b0;
         SHIFT_DATA  <= '0;
         clk_cnt     <= '0;
         bit_cnt     <= '0;
         frame       <= '0;
         msb_first   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               DONE <= 1'b0;
               if (IN_VALID && IN_READY) begin
                  state       <= DATA;
                  IN_READY    <= 1'b0;
                  BUSY        <= 1'b1;
                  SHIFT_CLOCK <= 1'b0;
                  frame       <= IN_DATA;
                  msb_first   <= IN_MSB_FIRST;
                  SHIFT_DATA  <= lane_bits(IN_DATA, IN_MSB_FIRST, 0);
                  clk_cnt     <= '0;
                  bit_cnt     <= '0;
               end
            end
            DATA: begin
               if (period_end) begin
                  SHIFT_CLOCK <= 1'b0;
                  clk_cnt     <= '0;
                  if (bit_cnt < BCW'(DATA_WIDTH - 1)) begin
                     bit_cnt    <= bit_nxt;
                     SHIFT_DATA <= lane_bits(frame, msb_first, int'(bit_nxt));
                  end else begin
                     state      <= LATCH;
                     SHIFT_DATA <= '0;
                  end
               end else begin
                  clk_cnt     <= clk_nxt;
                  SHIFT_CLOCK <= high_phase;
               end
            end
            LATCH: begin
               if (period_end) begin
                  state       <= IDLE;
                  SHIFT_LATCH <= 1'b0;
                  BUSY        <= 1'b0;
                  IN_READY    <= 1'b1;
                  DONE        <= 1'b1;
                  clk_cnt     <= '0;
               end else begin
                  clk_cnt     <= clk_nxt;
                  SHIFT_LATCH <= high_phase;
               end
            end
            default: begin
               state       <= IDLE;
               IN_READY    <= 1'b1;
               BUSY        <= 1'b0;
               DONE        <= 1'b0;
               SHIFT_CLOCK <= 1'b0;
               SHIFT_LATCH <= 1'b0;
               SHIFT_DATA  <= '0;
               clk_cnt     <= '0;
               bit_cnt     <= '0;
               frame       <= '0;
               msb_first   <= 1'b0;
            end
         endcase
      end
   end

`ifdef SHIFTOUT_READBACK_EN
   logic [FW-1:0] rb_acc;
   logic          sample_edge;

   // Sampling happens on the edge that raises SHIFT_CLOCK, before the chain itself shifts.
   assign sample_edge = (state == DATA) && !period_end && (clk_nxt == CCW'(HALF));

   function automatic logic [FW-1:0] rb_insert(input logic [FW-1:0] acc, input logic [CHANNELS-1:0] sin,
                                               input logic msb, input int idx);
      logic [FW-1:0] mask;
      for (int c = 0; c < CHANNELS; c++) begin
         mask = FW'(1) << (c * DATA_WIDTH + lane_pos(msb, idx));
         acc  = sin[c] ? (acc | mask) : (acc & ~mask);
      end
      return acc;
   endfunction

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         rb_acc  <= '0;
         RD_DATA <= '0;
      end else begin
         if (sample_edge)
            rb_acc <= rb_insert(rb_acc, SHIFT_IN, msb_first, int'(bit_cnt));
         if (state == LATCH && period_end)
            RD_DATA <= rb_acc;
      end
   end
`endif

endmodule

// File: tb/tb_shiftout_multi.sv
// Directed bench for shiftout_multi with 2 lanes of 8 bits at 4 clocks per bit.
// Readback checks are included when SHIFTOUT_READBACK_EN is defined.
module tb_shiftout_multi;

   localparam int DW  = 8;
   localparam int CH  = 2;
   localparam int CPB = 4;

   logic          CLK = 1'b0;
   logic          RST_N = 1'b0;
   logic [15:0]   IN_DATA = '0;
   logic          IN_MSB_FIRST = 1'b0;
   logic          IN_VALID = 1'b0;
   logic          IN_READY;
   logic          SHIFT_CLOCK;
   logic          SHIFT_LATCH;
   logic [CH-1:0] SHIFT_DATA;
   logic          BUSY;
   logic          DONE;

`ifdef SHIFTOUT_READBACK_EN
   logic [CH-1:0] SHIFT_IN;
   logic [15:0]   RD_DATA;
   logic [7:0]    model0 = '0;
   logic [7:0]    model1 = '0;

   // Behaves like one 8-bit 595 per lane, with the last stage looped back.
   always @(posedge SHIFT_CLOCK) begin
      model0 <= {model0[6:0], SHIFT_DATA[0]};
      model1 <= {model1[6:0], SHIFT_DATA[1]};
   end
   assign SHIFT_IN = {model1[7], model0[7]};
`endif

   shiftout_multi #(
      .DATA_WIDTH(DW),
      .CHANNELS(CH),
      .CLK_FREQ(4000),
      .FREQUENCY(1000)
   ) dut (
      .CLK(CLK),
      .RST_N(RST_N),
      .IN_DATA(IN_DATA),
      .IN_MSB_FIRST(IN_MSB_FIRST),
      .IN_VALID(IN_VALID),
      .IN_READY(IN_READY),
      .SHIFT_CLOCK(SHIFT_CLOCK),
      .SHIFT_LATCH(SHIFT_LATCH),
      .SHIFT_DATA(SHIFT_DATA),
      .BUSY(BUSY),
      .DONE(DONE)
`ifdef SHIFTOUT_READBACK_EN
      ,
      .SHIFT_IN(SHIFT_IN),
      .RD_DATA(RD_DATA)
`endif
   );

   always #5 CLK = ~CLK;

   int errors = 0;
   int checks = 0;
   int latch_rises = 0;

   always @(posedge SHIFT_LATCH) latch_rises++;

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   typedef struct {
      logic [15:0] data;
      logic        msb;
      logic [7:0]  seq0;
      logic [7:0]  seq1;
   } vec_t;

   vec_t vecs[6];

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Offers one frame at a negedge and records the serial waveform until IN_READY returns.
   task automatic applyStimulus(input logic [15:0] data, input logic msb, input logic keep_valid,
                                output logic [7:0] seq0, output logic [7:0] seq1, output int rises,
                                output int latch_high, output int cycles, output int unstable);
      logic          prev_clk;
      logic [CH-1:0] held;
      IN_DATA      = data;
      IN_MSB_FIRST = msb;
      IN_VALID     = 1'b1;
      checkOutput("ready_before_accept", 32'(IN_READY), 1);
      @(posedge CLK);
      seq0 = '0; seq1 = '0; rises = 0; latch_high = 0; cycles = 0; unstable = 0;
      prev_clk = 1'b0; held = '0;
      while (cycles < 200) begin
         @(negedge CLK);
         if (cycles == 0) begin
            checkOutput("busy_after_accept", 32'(BUSY), 1);
            if (!keep_valid) IN_VALID = 1'b0;
         end
         if (cycles == 10) IN_DATA = ~data;
         if (IN_READY) break;
         cycles++;
         if (SHIFT_CLOCK && !prev_clk) begin
            if (rises < 8) begin
               seq0 = seq0 | (8'(SHIFT_DATA[0]) << rises);
               seq1 = seq1 | (8'(SHIFT_DATA[1]) << rises);
            end
            rises++;
            held = SHIFT_DATA;
         end else if (SHIFT_CLOCK && SHIFT_DATA !== held) begin
            unstable++;
         end
         if (SHIFT_LATCH) begin
            latch_high++;
            if (SHIFT_DATA !== '0) unstable++;
         end
         prev_clk = SHIFT_CLOCK;
      end
      checkOutput("done_pulse", 32'(DONE), 1);
   endtask

   task automatic runFrame(input vec_t v, input logic keep_valid);
      logic [7:0] s0, s1;
      int r, lh, cyc, bad, lr_before;
      lr_before = latch_rises;
      applyStimulus(v.data, v.msb, keep_valid, s0, s1, r, lh, cyc, bad);
      checkOutput("lane0_bits", 32'(s0), 32'(v.seq0));
      checkOutput("lane1_bits", 32'(s1), 32'(v.seq1));
      checkOutput("clock_rises", r, 8);
      checkOutput("latch_width", lh, 2);
      checkOutput("latch_edges", latch_rises - lr_before, 1);
      checkOutput("frame_cycles", cyc, (DW + 1) * CPB);
      checkOutput("data_stable", bad, 0);
   endtask

   initial begin
      int lr_before;
`ifdef SHIFTOUT_READBACK_EN
      logic [7:0] d0, d1;
      int dr, dl, dc, du;
`endif
      vecs[0] = '{16'hA53C, 1'b0, 8'h3C, 8'hA5};
      vecs[1] = '{16'hA53C, 1'b1, 8'h3C, 8'hA5};
      vecs[2] = '{16'h0180, 1'b0, 8'h80, 8'h01};
      vecs[3] = '{16'h0180, 1'b1, 8'h01, 8'h80};
      vecs[4] = '{16'h1234, 1'b0, 8'h34, 8'h12};
      vecs[5] = '{16'h1234, 1'b1, 8'h2C, 8'h48};

      repeat (3) @(negedge CLK);
      RST_N = 1'b1;
      repeat (20) @(negedge CLK);
      checkOutput("reset_ready", 32'(IN_READY), 1);
      checkOutput("reset_busy", 32'(BUSY), 0);
      checkOutput("reset_done", 32'(DONE), 0);
      checkOutput("reset_latch", 32'(SHIFT_LATCH), 0);
      checkOutput("reset_clock", 32'(SHIFT_CLOCK), 0);
      checkOutput("reset_data", 32'(SHIFT_DATA), 0);
`ifdef SHIFTOUT_READBACK_EN
      checkOutput("reset_rd_data", 32'(RD_DATA), 0);
`endif

      for (int i = 0; i < 6; i++) begin
         runFrame(vecs[i], 1'b0);
         @(negedge CLK);
         checkOutput("done_one_cycle", 32'(DONE), 0);
      end

      // IN_VALID held across two frames: the second is taken on the DONE cycle.
      runFrame(vecs[2], 1'b1);
      runFrame(vecs[5], 1'b0);
      @(negedge CLK);

      // Reset while bit 5 is on the wire must not commit the partial frame.
      IN_DATA = 16'hA53C; IN_MSB_FIRST = 1'b0; IN_VALID = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      IN_VALID = 1'b0;
      repeat (21) @(negedge CLK);
      lr_before = latch_rises;
      #2 RST_N = 1'b0;
      #1;
      checkOutput("midreset_busy", 32'(BUSY), 0);
      checkOutput("midreset_ready", 32'(IN_READY), 1);
      checkOutput("midreset_clock", 32'(SHIFT_CLOCK), 0);
      checkOutput("midreset_data", 32'(SHIFT_DATA), 0);
      checkOutput("midreset_latch", 32'(SHIFT_LATCH), 0);
      repeat (3) @(negedge CLK);
      RST_N = 1'b1;
      @(negedge CLK);
      checkOutput("midreset_no_latch_edge", latch_rises - lr_before, 0);
      runFrame(vecs[5], 1'b0);
      @(negedge CLK);

`ifdef SHIFTOUT_READBACK_EN
      applyStimulus(16'hC35A, 1'b0, 1'b0, d0, d1, dr, dl, dc, du);
      @(negedge CLK);
      applyStimulus(16'h0F96, 1'b0, 1'b0, d0, d1, dr, dl, dc, du);
      checkOutput("readback_lsb", 32'(RD_DATA), 32'h0000C35A);
      @(negedge CLK);
      applyStimulus(16'h6B2D, 1'b1, 1'b0, d0, d1, dr, dl, dc, du);
      @(negedge CLK);
      applyStimulus(16'h1E87, 1'b1, 1'b0, d0, d1, dr, dl, dc, du);
      checkOutput("readback_msb", 32'(RD_DATA), 32'h00006B2D);
      repeat (5) @(negedge CLK);
      checkOutput("readback_hold", 32'(RD_DATA), 32'h00006B2D);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
